crc_stream_engine: RTL and testbench
====================================

Name: crc_stream_engine

Overview:
- Multi-byte streaming CRC engine with a valid/ready input handshake and packet framing through a last flag and a byte keep mask.
- Accumulates one CRC per packet and presents a registered result with a byte count and an optional pass/fail check.
- Successor to the single-beat fixed-width CRC register: generalised to DATA_BYTES lanes per beat, partial last beats, backpressure, a proper output reflection and a check mode.
- Sits between the MAC/stream ingress and the packet-validation logic.

Parameters:
POLY, 64'h04C11DB7, generator polynomial; low CRC_SIZE bits used, implicit top bit
CRC_SIZE, 32, CRC width in bits, 8..64
INIT, 64'hFFFFFFFF, CRC register preset at packet start
REF_IN, 1, 1 = each byte processed LSB-first; 0 = MSB-first
REF_OUT, 1, 1 = bit-reverse the final register before XOR_OUT
XOR_OUT, 64'hFFFFFFFF, value XORed onto the final CRC
DATA_BYTES, 4, byte lanes per beat, 1..16
LEN_WIDTH, 16, width of the packet byte counter
CHECK_EN, 0, 1 = drive res_ok_o from the CHECK_VALUE comparison; 0 = res_ok_o tied 0
CHECK_VALUE, 64'h2144DF1C, expected res_crc_o for a packet that carries its own CRC

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
soft_reset_i  in  1  synchronous abort: drops the current packet and any pending result
s_valid_i  in  1  input beat valid
s_ready_o  out  1  engine accepts a beat
s_data_i  in  8*DATA_BYTES  payload; byte k = bits [8k+7:8k]; byte 0 is processed first
s_keep_i  in  DATA_BYTES  byte enables; must be contiguous from bit 0
s_last_i  in  1  final beat of the packet
res_valid_o  out  1  result valid
res_ready_i  in  1  result consumed
res_crc_o  out  CRC_SIZE  final CRC (reflected per REF_OUT, then XOR_OUT applied)
res_len_o  out  LEN_WIDTH  packet length in bytes
res_ok_o  out  1  res_crc_o == CHECK_VALUE[CRC_SIZE-1:0] when CHECK_EN=1

Behaviour:
- Beat accepted when s_valid_i && s_ready_o.
- Accepted beat: bytes with keep=1 are folded into the CRC in lane order, all lanes in the same cycle (DATA_BYTES cascaded byte updates).
- keep=0 lanes are ignored.
- Non-contiguous keep is undefined; the bench asserts contiguity.
- Bit order per byte: REF_IN=1 → bit 0 first, using the reflected-polynomial shift-right update; REF_IN=0 → bit 7 first, shift-left update.
- FSM states: IDLE, ACCUM, RESULT.
- IDLE: crc = INIT, len = 0, s_ready_o = 1.
  - Accepted beat with last=0 → ACCUM.
  - Accepted beat with last=1 → RESULT.
- ACCUM: s_ready_o = 1. Accepted beat with last=1 → RESULT.
- RESULT: s_ready_o = 0, res_valid_o = 1. Outputs are stable while res_ready_i = 0. Handshake (res_valid_o && res_ready_i) → IDLE.
- Latency: last beat accepted at cycle N → res_valid_o = 1 at N+1. Earliest next beat accept is N+2, so there is one bubble per packet.
- Length: len += popcount(keep) per accepted beat; saturates at 2^LEN_WIDTH-1 with no wrap.
- A last beat with keep=0 is legal. If it is the first beat, the packet has zero length: res_crc_o = reflect?(INIT) ^ XOR_OUT and res_len_o = 0.
- Output reset values: s_ready_o = 0 during reset and 1 in the first cycle after release; res_valid_o = 0; res_crc_o = 0; res_len_o = 0; res_ok_o = 0.
- soft_reset_i takes priority over everything. Next cycle: IDLE, crc = INIT, len = 0, res_valid_o = 0. Any beat offered in the same cycle is not folded in; s_ready_o stays as the FSM drives it and the beat is lost by design.
- rst_n_i asserted mid-packet or mid-result: immediate return to IDLE reset values; the pending result is lost.
- Result registers load only on the IDLE/ACCUM → RESULT transition.

Decomposition:
- Package crc_stream_pkg holds:
  - FSM state enum (IDLE, ACCUM, RESULT);
  - preset constants CRC32_ETH and CRC16_ARC (POLY/INIT/REF/XOR values);
  - function reflect_n.
- Sub-module crc_byte_update: combinational, parameters POLY, CRC_SIZE, REF_IN; inputs crc_in and byte; output crc_out.
- The top instantiates DATA_BYTES of these in a chain, with a keep-controlled bypass mux per lane.

Test Plan:
- Defaults, beats "1234", "5678", "9" with keep 1111, 1111, 0001, last on beat 3 → res_crc_o = 0xCBF43926, res_len_o = 9, res_valid_o one cycle after the last accept.
- CRC_SIZE=16, POLY=16'h8005, INIT=0, REF_IN=1, REF_OUT=1, XOR_OUT=0, DATA_BYTES=1, "123456789" → 0xBB3D, res_len_o = 9.
- CHECK_EN=1, defaults, "123456789" followed by bytes 26 39 F4 CB → res_crc_o = 0x2144DF1C, res_ok_o = 1. Flip one payload bit → res_ok_o = 0.
- Hold res_ready_i = 0 for 5 cycles with a second packet pending on s_valid_i → s_ready_o = 0 and outputs stable throughout. After the handshake, the second packet gives 0xCBF43926.
- Zero-length packet (one beat, keep = 0000, last = 1) → res_crc_o = 0x00000000, res_len_o = 0.
- soft_reset_i after beat 1 of "123456789", then a full resend → exactly one result, 0xCBF43926. Separately, pulse rst_n_i low asynchronously mid-packet → outputs are 0 immediately.

Source files
------------

// File: rtl/crc_stream_pkg.sv
// ---------------------------------------------------------------------------
// crc_stream_pkg
// Shared types and helpers for the streaming CRC engine.
//   state_t      : engine FSM states (IDLE, ACCUM, RESULT)
//   crc_preset_t : bundle of the parameters that define one CRC flavour
//   CRC32_ETH    : Ethernet / zlib CRC-32
//   CRC16_ARC    : CRC-16/ARC
//   reflect_n()  : bit-reverse the low 'width' bits of a 64-bit value
// ---------------------------------------------------------------------------
package crc_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESULT
    } state_t;

    typedef struct packed {
        logic [63:0] poly;
        logic [63:0] init;
        logic        ref_in;
        logic        ref_out;
        logic [63:0] xor_out;
    } crc_preset_t;

    localparam crc_preset_t CRC32_ETH = '{
        poly:    64'h04C11DB7,
        init:    64'hFFFFFFFF,
        ref_in:  1'b1,
        ref_out: 1'b1,
        xor_out: 64'hFFFFFFFF
    };

    localparam crc_preset_t CRC16_ARC = '{
        poly:    64'h8005,
        init:    64'h0,
        ref_in:  1'b1,
        ref_out: 1'b1,
        xor_out: 64'h0
    };

    // Bits at and above 'width' come back as zero.
    function automatic logic [63:0] reflect_n(input logic [63:0] value, input int width);
        logic [63:0] result;
        result = '0;
        for (int i = 0; i < 64; i++) begin
            if (i < width) begin
                result[i] = value[width - 1 - i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/crc_byte_update.sv
// ---------------------------------------------------------------------------
// crc_byte_update
// Combinational fold of one byte into a CRC register.
//   crc_in    : register value before the byte
//   data_byte : byte to fold in
//   crc_out   : register value after the byte
// With REF_IN=1 the register is kept in reflected form: the byte enters at the
// LSB end and the reflected polynomial is used with right shifts (bit 0 of the
// byte first). With REF_IN=0 the byte enters at the MSB end with left shifts.
// ---------------------------------------------------------------------------
module crc_byte_update
    import crc_stream_pkg::*;
#(
    parameter logic [63:0] POLY     = 64'h04C11DB7,
    parameter int          CRC_SIZE = 32,
    parameter int          REF_IN   = 1
) (
    input  logic [CRC_SIZE-1:0] crc_in,
    input  logic [7:0]          data_byte,
    output logic [CRC_SIZE-1:0] crc_out
);

    localparam logic [63:0]         POLY_REF_64 = reflect_n(POLY, CRC_SIZE);
    localparam logic [CRC_SIZE-1:0] POLY_FWD    = POLY[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0] POLY_REF    = POLY_REF_64[CRC_SIZE-1:0];

    logic [CRC_SIZE-1:0] work;

    // Eight single-bit LFSR steps unrolled into one combinational cone.
    always_comb begin
        work = crc_in;
        if (REF_IN != 0) begin
            work = work ^ CRC_SIZE'(data_byte);
            for (int b = 0; b < 8; b++) begin
                work = work[0] ? ((work >> 1) ^ POLY_REF) : (work >> 1);
            end
        end else begin
            work = work ^ (CRC_SIZE'(data_byte) << (CRC_SIZE - 8));
            for (int b = 0; b < 8; b++) begin
                work = work[CRC_SIZE-1] ? ((work << 1) ^ POLY_FWD) : (work << 1);
            end
        end
        crc_out = work;
    end

endmodule

// File: rtl/crc_stream_engine.sv
// ---------------------------------------------------------------------------
// crc_stream_engine
// Streaming multi-lane CRC with valid/ready input, last/keep framing and a
// registered per-packet result.
//   clk_i, rst_n_i   : clock, asynchronous active-low reset
//   soft_reset_i     : synchronous abort of packet and pending result
//   s_valid_i/s_ready_o, s_data_i, s_keep_i, s_last_i : input beat stream
//   res_valid_o/res_ready_i : result handshake
//   res_crc_o, res_len_o, res_ok_o : final CRC, byte count, check flag
// ---------------------------------------------------------------------------
module crc_stream_engine
    import crc_stream_pkg::*;
#(
    parameter logic [63:0] POLY        = 64'h04C11DB7,
    parameter int          CRC_SIZE    = 32,
    parameter logic [63:0] INIT        = 64'hFFFFFFFF,
    parameter int          REF_IN      = 1,
    parameter int          REF_OUT     = 1,
    parameter logic [63:0] XOR_OUT     = 64'hFFFFFFFF,
    parameter int          DATA_BYTES  = 4,
    parameter int          LEN_WIDTH   = 16,
    parameter int          CHECK_EN    = 0,
    parameter logic [63:0] CHECK_VALUE = 64'h2144DF1C
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    soft_reset_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [8*DATA_BYTES-1:0] s_data_i,
    input  logic [DATA_BYTES-1:0]   s_keep_i,
    input  logic                    s_last_i,
    output logic                    res_valid_o,
    input  logic                    res_ready_i,
    output logic [CRC_SIZE-1:0]     res_crc_o,
    output logic [LEN_WIDTH-1:0]    res_len_o,
    output logic                    res_ok_o
);

    // A reflected register holds INIT in reflected form, so the preset and the
    // output reflection are both relative to that: the output is only
    // bit-reversed when REF_OUT differs from REF_IN.
    localparam logic [63:0]          INIT_REF_64 = reflect_n(INIT, CRC_SIZE);
    localparam logic [CRC_SIZE-1:0]  CRC_PRESET  = (REF_IN != 0) ? INIT_REF_64[CRC_SIZE-1:0]
                                                                 : INIT[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0]  XOR_N       = XOR_OUT[CRC_SIZE-1:0];
    localparam logic [CRC_SIZE-1:0]  CHECK_N     = CHECK_VALUE[CRC_SIZE-1:0];
    localparam logic [LEN_WIDTH-1:0] LEN_MAX     = '1;

    state_t               state_q, state_d;
    logic                 ready_q, ready_d;
    logic                 accept;
    logic                 load_result;

    logic [CRC_SIZE-1:0]  crc_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [CRC_SIZE-1:0]  chain [DATA_BYTES+1];
    logic [CRC_SIZE-1:0]  lane_upd [DATA_BYTES];
    logic [CRC_SIZE-1:0]  crc_raw, crc_refl, crc_final, crc_out_d;
    logic [LEN_WIDTH:0]   keep_count, len_sum;
    logic [LEN_WIDTH-1:0] len_next;

    logic [CRC_SIZE-1:0]  res_crc_q;
    logic [LEN_WIDTH-1:0] res_len_q;
    logic                 res_ok_q;

    assign accept      = s_valid_i && ready_q;
    assign s_ready_o   = ready_q;
    assign res_valid_o = (state_q == RESULT);
    assign res_crc_o   = res_crc_q;
    assign res_len_o   = res_len_q;
    assign res_ok_o    = res_ok_q;

    // Lane chain: lane 0 sees the stored register, each later lane sees the
    // previous lane's result, and a lane with keep=0 passes its input through.
    assign chain[0] = crc_q;
    for (genvar lane = 0; lane < DATA_BYTES; lane++) begin : g_lane
        crc_byte_update #(
            .POLY     (POLY),
            .CRC_SIZE (CRC_SIZE),
            .REF_IN   (REF_IN)
        ) u_byte_update (
            .crc_in    (chain[lane]),
            .data_byte (s_data_i[8*lane +: 8]),
            .crc_out   (lane_upd[lane])
        );
        assign chain[lane+1] = s_keep_i[lane] ? lane_upd[lane] : chain[lane];
    end

    assign crc_raw = chain[DATA_BYTES];

    // Finalisation of the register as it would stand after this beat.
    always_comb begin
        crc_refl = '0;
        for (int i = 0; i < CRC_SIZE; i++) begin
            crc_refl[i] = crc_raw[CRC_SIZE - 1 - i];
        end
        crc_final = (REF_OUT != REF_IN) ? crc_refl : crc_raw;
        crc_out_d = crc_final ^ XOR_N;
    end

    // Byte count for this beat; the one-bit-wider sum catches overflow so the
    // length sticks at its maximum instead of wrapping.
    always_comb begin
        keep_count = '0;
        for (int k = 0; k < DATA_BYTES; k++) begin
            keep_count = keep_count + {{LEN_WIDTH{1'b0}}, s_keep_i[k]};
        end
        len_sum  = {1'b0, len_q} + keep_count;
        len_next = len_sum[LEN_WIDTH] ? LEN_MAX : len_sum[LEN_WIDTH-1:0];
    end

    // Next-state logic. Soft reset overrides everything and throws away any
    // beat offered in the same cycle. Ready is registered from the next state,
    // which keeps it low through reset and for the one-cycle result bubble.
    always_comb begin
        state_d     = state_q;
        load_result = 1'b0;
        case (state_q)
            IDLE, ACCUM: begin
                if (accept) begin
                    state_d     = s_last_i ? RESULT : ACCUM;
                    load_result = s_last_i;
                end
            end
            RESULT: begin
                if (res_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (soft_reset_i) begin
            state_d     = IDLE;
            load_result = 1'b0;
        end
        ready_d = (state_d != RESULT);
    end

    // State and ready registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Accumulator and result registers. The accumulator is re-preset as soon
    // as the result is captured, so IDLE always starts from a clean register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q     <= CRC_PRESET;
            len_q     <= '0;
            res_crc_q <= '0;
            res_len_q <= '0;
            res_ok_q  <= 1'b0;
        end else if (soft_reset_i) begin
            crc_q     <= CRC_PRESET;
            len_q     <= '0;
            res_crc_q <= '0;
            res_len_q <= '0;
            res_ok_q  <= 1'b0;
        end else if (load_result) begin
            crc_q     <= CRC_PRESET;
            len_q     <= '0;
            res_crc_q <= crc_out_d;
            res_len_q <= len_next;
            res_ok_q  <= (CHECK_EN != 0) && (crc_out_d == CHECK_N);
        end else if (accept) begin
            crc_q <= crc_raw;
            len_q <= len_next;
        end
    end

endmodule

// File: tb/tb_crc_stream_engine.sv
// ---------------------------------------------------------------------------
// tb_crc_stream_engine
// Directed bench for crc_stream_engine: a default CRC-32 instance, a CRC-32
// instance with the residue check enabled (sharing the same input stream) and
// a single-lane CRC-16/ARC instance.
// ---------------------------------------------------------------------------
module tb_crc_stream_engine;
    import crc_stream_pkg::*;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        soft_reset = 1'b0;
    logic        s_valid    = 1'b0;
    logic [31:0] s_data     = '0;
    logic [3:0]  s_keep     = '0;
    logic        s_last     = 1'b0;
    logic        res_ready  = 1'b0;

    logic        s_ready, res_valid, res_ok;
    logic [31:0] res_crc;
    logic [15:0] res_len;

    logic        c_s_ready, c_res_valid, c_res_ok;
    logic [31:0] c_res_crc;
    logic [15:0] c_res_len;

    logic        h_valid = 1'b0;
    logic [7:0]  h_data  = '0;
    logic [0:0]  h_keep  = '0;
    logic        h_last  = 1'b0;
    logic        h_ready, h_res_valid, h_res_ok;
    logic [15:0] h_res_crc;
    logic [15:0] h_res_len;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    crc_stream_engine dut (
        .clk_i (clk), .rst_n_i (rst_n), .soft_reset_i (soft_reset),
        .s_valid_i (s_valid), .s_ready_o (s_ready), .s_data_i (s_data),
        .s_keep_i (s_keep), .s_last_i (s_last),
        .res_valid_o (res_valid), .res_ready_i (res_ready),
        .res_crc_o (res_crc), .res_len_o (res_len), .res_ok_o (res_ok)
    );

    crc_stream_engine #(.CHECK_EN(1)) dut_chk (
        .clk_i (clk), .rst_n_i (rst_n), .soft_reset_i (soft_reset),
        .s_valid_i (s_valid), .s_ready_o (c_s_ready), .s_data_i (s_data),
        .s_keep_i (s_keep), .s_last_i (s_last),
        .res_valid_o (c_res_valid), .res_ready_i (res_ready),
        .res_crc_o (c_res_crc), .res_len_o (c_res_len), .res_ok_o (c_res_ok)
    );

    crc_stream_engine #(
        .POLY (CRC16_ARC.poly), .CRC_SIZE (16), .INIT (CRC16_ARC.init),
        .REF_IN (1), .REF_OUT (1), .XOR_OUT (CRC16_ARC.xor_out), .DATA_BYTES (1)
    ) dut16 (
        .clk_i (clk), .rst_n_i (rst_n), .soft_reset_i (soft_reset),
        .s_valid_i (h_valid), .s_ready_o (h_ready), .s_data_i (h_data),
        .s_keep_i (h_keep), .s_last_i (h_last),
        .res_valid_o (h_res_valid), .res_ready_i (res_ready),
        .res_crc_o (h_res_crc), .res_len_o (h_res_len), .res_ok_o (h_res_ok)
    );

    // Keep must be contiguous from lane 0 on every accepted beat.
    always @(posedge clk) begin
        if (s_valid && s_ready) begin
            assert ((s_keep & (s_keep + 4'd1)) == 4'd0)
                else $error("[TB] non-contiguous keep %b", s_keep);
        end
    end

    // Called at a negedge; returns at the negedge after the beat was taken.
    task automatic send_beat(input logic [31:0] data, input logic [3:0] keep, input logic last);
        int waited;
        waited  = 0;
        s_valid = 1'b1;
        s_data  = data;
        s_keep  = keep;
        s_last  = last;
        while (!s_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (s_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL beat accept timeout: s_ready=%b want 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_keep  = '0;
        s_data  = '0;
    endtask

    task automatic h_send_byte(input logic [7:0] data, input logic last);
        int waited;
        waited  = 0;
        h_valid = 1'b1;
        h_data  = data;
        h_keep  = 1'b1;
        h_last  = last;
        while (!h_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (h_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL crc16 accept timeout: s_ready=%b want 1", h_ready);
        end
        @(negedge clk);
        h_valid = 1'b0;
        h_last  = 1'b0;
        h_keep  = '0;
    endtask

    task automatic send_123456789();
        send_beat(32'h34333231, 4'b1111, 1'b0);
        send_beat(32'h38373635, 4'b1111, 1'b0);
        send_beat(32'h00000039, 4'b0001, 1'b1);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset s_ready: got %b want 0", s_ready); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset res_valid: got %b want 0", res_valid); end
        vectors++; if (res_crc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset res_crc: got %h want 0", res_crc); end
        vectors++; if (res_len !== 16'h0) begin miscompares++; $display("[TB] FAIL reset res_len: got %h want 0", res_len); end
        vectors++; if (c_res_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL reset res_ok: got %b want 0", c_res_ok); end
        vectors++; if (h_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset crc16 s_ready: got %b want 0", h_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL release s_ready: got %b want 1", s_ready); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL release res_valid: got %b want 0", res_valid); end
    endtask

    task automatic test_crc32_basic();
        send_beat(32'h34333231, 4'b1111, 1'b0);
        send_beat(32'h38373635, 4'b1111, 1'b0);
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic early valid: got %b want 0", res_valid); end
        send_beat(32'h00000039, 4'b0001, 1'b1);
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL basic latency valid: got %b want 1", res_valid); end
        vectors++; if (res_crc !== 32'hCBF43926) begin miscompares++; $display("[TB] FAIL basic crc: got %h want cbf43926", res_crc); end
        vectors++; if (res_len !== 16'd9) begin miscompares++; $display("[TB] FAIL basic len: got %0d want 9", res_len); end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL basic bubble s_ready: got %b want 0", s_ready); end
        vectors++; if (res_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL basic res_ok tied: got %b want 0", res_ok); end
        vectors++; if (c_res_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL basic check res_ok: got %b want 0", c_res_ok); end
        consume();
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL basic after handshake valid: got %b want 0", res_valid); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL basic after handshake s_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_crc16();
        logic [71:0] msg;
        msg = 72'h313233343536373839;
        for (int i = 8; i >= 0; i--) begin
            h_send_byte(msg[8*i +: 8], i == 0);
        end
        vectors++; if (h_res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL crc16 valid: got %b want 1", h_res_valid); end
        vectors++; if (h_res_crc !== 16'hBB3D) begin miscompares++; $display("[TB] FAIL crc16 crc: got %h want bb3d", h_res_crc); end
        vectors++; if (h_res_len !== 16'd9) begin miscompares++; $display("[TB] FAIL crc16 len: got %0d want 9", h_res_len); end
        vectors++; if (h_res_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL crc16 res_ok: got %b want 0", h_res_ok); end
        consume();
        vectors++; if (h_res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL crc16 after handshake: got %b want 0", h_res_valid); end
    endtask

    task automatic test_check_mode();
        send_beat(32'h34333231, 4'b1111, 1'b0);
        send_beat(32'h38373635, 4'b1111, 1'b0);
        send_beat(32'hF4392639, 4'b1111, 1'b0);
        send_beat(32'h000000CB, 4'b0001, 1'b1);
        vectors++; if (c_res_crc !== 32'h2144DF1C) begin miscompares++; $display("[TB] FAIL check residue: got %h want 2144df1c", c_res_crc); end
        vectors++; if (c_res_ok !== 1'b1) begin miscompares++; $display("[TB] FAIL check res_ok good: got %b want 1", c_res_ok); end
        vectors++; if (c_res_len !== 16'd13) begin miscompares++; $display("[TB] FAIL check len: got %0d want 13", c_res_len); end
        vectors++; if (res_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL check disabled res_ok: got %b want 0", res_ok); end
        consume();
        send_beat(32'h34333230, 4'b1111, 1'b0);
        send_beat(32'h38373635, 4'b1111, 1'b0);
        send_beat(32'hF4392639, 4'b1111, 1'b0);
        send_beat(32'h000000CB, 4'b0001, 1'b1);
        vectors++; if (c_res_ok !== 1'b0) begin miscompares++; $display("[TB] FAIL check res_ok corrupted: got %b want 0", c_res_ok); end
        vectors++; if (c_res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL check corrupted valid: got %b want 1", c_res_valid); end
        consume();
    endtask

    task automatic test_back_to_back();
        send_123456789();
        s_valid = 1'b1;
        s_data  = 32'h34333231;
        s_keep  = 4'b1111;
        s_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL hold s_ready cycle %0d: got %b want 0", c, s_ready); end
            vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL hold res_valid cycle %0d: got %b want 1", c, res_valid); end
            vectors++; if (res_crc !== 32'hCBF43926) begin miscompares++; $display("[TB] FAIL hold res_crc cycle %0d: got %h want cbf43926", c, res_crc); end
            vectors++; if (res_len !== 16'd9) begin miscompares++; $display("[TB] FAIL hold res_len cycle %0d: got %0d want 9", c, res_len); end
            @(negedge clk);
        end
        consume();
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b released valid: got %b want 0", res_valid); end
        send_123456789();
        vectors++; if (res_crc !== 32'hCBF43926) begin miscompares++; $display("[TB] FAIL b2b second crc: got %h want cbf43926", res_crc); end
        vectors++; if (res_len !== 16'd9) begin miscompares++; $display("[TB] FAIL b2b second len: got %0d want 9", res_len); end
        consume();
    endtask

    task automatic test_zero_length();
        send_beat(32'hDEADBEEF, 4'b0000, 1'b1);
        vectors++; if (res_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL zero-length valid: got %b want 1", res_valid); end
        vectors++; if (res_crc !== 32'h00000000) begin miscompares++; $display("[TB] FAIL zero-length crc: got %h want 0", res_crc); end
        vectors++; if (res_len !== 16'd0) begin miscompares++; $display("[TB] FAIL zero-length len: got %0d want 0", res_len); end
        consume();
    endtask

    task automatic test_len_saturation();
        for (int b = 0; b < 16384; b++) begin
            send_beat(32'h0, 4'b1111, 1'b0);
        end
        send_beat(32'h0, 4'b0001, 1'b1);
        vectors++; if (res_len !== 16'hFFFF) begin miscompares++; $display("[TB] FAIL length saturation: got %h want ffff", res_len); end
        consume();
    endtask

    task automatic test_soft_reset();
        send_beat(32'h34333231, 4'b1111, 1'b0);
        soft_reset = 1'b1;
        s_valid    = 1'b1;
        s_data     = 32'h38373635;
        s_keep     = 4'b1111;
        @(negedge clk);
        soft_reset = 1'b0;
        s_valid    = 1'b0;
        s_keep     = '0;
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL soft reset valid: got %b want 0", res_valid); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL soft reset s_ready: got %b want 1", s_ready); end
        send_123456789();
        vectors++; if (res_crc !== 32'hCBF43926) begin miscompares++; $display("[TB] FAIL soft reset resend crc: got %h want cbf43926", res_crc); end
        vectors++; if (res_len !== 16'd9) begin miscompares++; $display("[TB] FAIL soft reset resend len: got %0d want 9", res_len); end
        consume();
        repeat (3) @(negedge clk);
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL soft reset extra result: got %b want 0", res_valid); end
        send_beat(32'h0, 4'b0000, 1'b1);
        soft_reset = 1'b1;
        @(negedge clk);
        soft_reset = 1'b0;
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL soft reset drops result: got %b want 0", res_valid); end
    endtask

    task automatic test_async_reset();
        send_123456789();
        consume();
        vectors++; if (res_crc !== 32'hCBF43926) begin miscompares++; $display("[TB] FAIL pre-reset crc held: got %h want cbf43926", res_crc); end
        send_beat(32'h34333231, 4'b1111, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL async s_ready: got %b want 0", s_ready); end
        vectors++; if (res_crc !== 32'h0) begin miscompares++; $display("[TB] FAIL async res_crc: got %h want 0", res_crc); end
        vectors++; if (res_len !== 16'h0) begin miscompares++; $display("[TB] FAIL async res_len: got %h want 0", res_len); end
        vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL async res_valid: got %b want 0", res_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_123456789();
        vectors++; if (res_crc !== 32'hCBF43926) begin miscompares++; $display("[TB] FAIL post-reset crc: got %h want cbf43926", res_crc); end
        consume();
    endtask

    initial begin
        $display("[TB] crc_stream_engine directed bench");
        test_reset();
        test_crc32_basic();
        test_crc16();
        test_check_mode();
        test_back_to_back();
        test_zero_length();
        test_soft_reset();
        test_len_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
